// File: rtl/animated_pattern_gen_pkg.sv
// Shared definitions for the animated test pattern generator: pattern IDs,
// colour-bar ordering, frame-counter width and handshake state encoding.
package animated_pattern_gen_pkg;

  localparam logic [3:0] PAT_BLACK   = 4'd0;
  localparam logic [3:0] PAT_RED     = 4'd1;
  localparam logic [3:0] PAT_GREEN   = 4'd2;
  localparam logic [3:0] PAT_BLUE    = 4'd3;
  localparam logic [3:0] PAT_BARS    = 4'd4;
  localparam logic [3:0] PAT_BORDER  = 4'd5;
  localparam logic [3:0] PAT_CHECKER = 4'd6;
  localparam logic [3:0] PAT_SCROLL  = 4'd7;
  localparam logic [3:0] PAT_BOX     = 4'd8;
  localparam logic [3:0] PAT_HRAMP   = 4'd9;

  localparam int FRAME_CNT_W = 8;
  localparam int NUM_BARS    = 8;

  typedef enum logic {
    HS_IDLE    = 1'b0,
    HS_PENDING = 1'b1
  } hs_state_t;

  // Colour of each vertical bar, left to right, as {red, green, blue} on/off bits
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;  // white
      3'd1:    c = 3'b110;  // yellow
      3'd2:    c = 3'b011;  // cyan
      3'd3:    c = 3'b010;  // green
      3'd4:    c = 3'b101;  // magenta
      3'd5:    c = 3'b100;  // red
      3'd6:    c = 3'b001;  // blue
      default: c = 3'b000;  // black
    endcase
    return c;
  endfunction

endpackage

// File: rtl/animated_pattern_gen_bounce_box.sv
// Bouncing box position tracker: x/y position, direction bits and edge
// reversal, plus a combinational flag telling whether a pixel is inside the box.
module tpg_bounce_box
  import animated_pattern_gen_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int BOX_SIZE  = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  output logic       o_inside
);

  localparam logic [9:0]  X_MAX   = 10'(H_VISIBLE - BOX_SIZE);
  localparam logic [9:0]  Y_MAX   = 10'(V_VISIBLE - BOX_SIZE);
  localparam logic [10:0] BOX_LEN = 11'(BOX_SIZE);

  logic [9:0] x_q;
  logic [9:0] y_q;
  logic       dir_x_q;
  logic       dir_y_q;

  // Move one pixel per axis per step; at a limit, reverse and step inward in the same update
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else if (i_step) begin
      if (dir_x_q) begin
        if (x_q >= X_MAX) begin
          dir_x_q <= 1'b0;
          x_q     <= x_q - 10'd1;
        end else begin
          x_q     <= x_q + 10'd1;
        end
      end else begin
        if (x_q == 10'd0) begin
          dir_x_q <= 1'b1;
          x_q     <= x_q + 10'd1;
        end else begin
          x_q     <= x_q - 10'd1;
        end
      end
      if (dir_y_q) begin
        if (y_q >= Y_MAX) begin
          dir_y_q <= 1'b0;
          y_q     <= y_q - 10'd1;
        end else begin
          y_q     <= y_q + 10'd1;
        end
      end else begin
        if (y_q == 10'd0) begin
          dir_y_q <= 1'b1;
          y_q     <= y_q + 10'd1;
        end else begin
          y_q     <= y_q - 10'd1;
        end
      end
    end
  end

  // Half-open containment test, widened by one bit so x+BOX_SIZE cannot overflow
  always_comb begin
    o_inside = ({1'b0, i_hpos} >= {1'b0, x_q}) &&
               ({1'b0, i_hpos} <  ({1'b0, x_q} + BOX_LEN)) &&
               ({1'b0, i_vpos} >= {1'b0, y_q}) &&
               ({1'b0, i_vpos} <  ({1'b0, y_q} + BOX_LEN));
  end

endmodule

// File: rtl/animated_pattern_gen.sv
// Animated VGA test pattern generator with frame-synchronous pattern switching.
// Colour and syncs are registered together, one cycle after the inputs.
// Optional build macro TPG_FREEZE_EN adds i_freeze, which holds the animation
// state (frame counter and bouncing box) while high.
module animated_pattern_gen
  import animated_pattern_gen_pkg::*;
#(
  parameter int COLOR_BITS   = 3,
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int BORDER_WIDTH = 8,
  parameter int BOX_SIZE     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [3:0]            i_pattern,
  input  logic                  i_pattern_valid,
  output logic                  o_pattern_ready,
  output logic [3:0]            o_active_pattern,
  input  logic [9:0]            i_hpos,
  input  logic [9:0]            i_vpos,
  input  logic                  i_visible,
  input  logic                  i_hsync,
  input  logic                  i_vsync,
  input  logic                  i_frame_strobe,
`ifdef TPG_FREEZE_EN
  input  logic                  i_freeze,
`endif
  output logic [COLOR_BITS-1:0] o_red_video,
  output logic [COLOR_BITS-1:0] o_grn_video,
  output logic [COLOR_BITS-1:0] o_blu_video,
  output logic                  o_hsync,
  output logic                  o_vsync
);

  localparam logic [COLOR_BITS-1:0] FULL          = {COLOR_BITS{1'b1}};
  localparam logic [9:0]            BAR_WIDTH     = 10'(H_VISIBLE / NUM_BARS);
  localparam logic [9:0]            BORDER_NEAR   = 10'(BORDER_WIDTH);
  localparam logic [9:0]            BORDER_RIGHT  = 10'(H_VISIBLE - BORDER_WIDTH);
  localparam logic [9:0]            BORDER_BOTTOM = 10'(V_VISIBLE - BORDER_WIDTH);

  hs_state_t               state_q, state_d;
  logic [3:0]              pending_q, pending_d;
  logic [3:0]              active_q, active_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q;
  logic                    anim_step;
  logic                    in_box;
  logic [9:0]              bar_num;
  logic [2:0]              bar_rgb;
  logic                    on_border;
  logic [10:0]             scroll_sum;
  logic [COLOR_BITS-1:0]   scroll_level;
  logic [COLOR_BITS-1:0]   hramp_level;
  logic [COLOR_BITS-1:0]   red_d, grn_d, blu_d;

`ifdef TPG_FREEZE_EN
  assign anim_step = i_frame_strobe & ~i_freeze;
`else
  assign anim_step = i_frame_strobe;
`endif

  assign o_pattern_ready  = (state_q == HS_IDLE);
  assign o_active_pattern = active_q;

  // Handshake state, pending ID and displayed pattern registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= HS_IDLE;
      pending_q <= 4'd0;
      active_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  // Accept a request when idle; commit it on the first strobe seen while pending
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    case (state_q)
      HS_IDLE: begin
        if (i_pattern_valid) begin
          pending_d = i_pattern;
          state_d   = HS_PENDING;
        end
      end
      HS_PENDING: begin
        if (i_frame_strobe) begin
          active_d  = pending_q;
          pending_d = 4'd0;
          state_d   = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  // Frame counter drives the scrolling ramp and advances once per frame
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
    end else if (anim_step) begin
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  tpg_bounce_box #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE),
    .BOX_SIZE  (BOX_SIZE)
  ) u_box (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_step   (anim_step),
    .i_hpos   (i_hpos),
    .i_vpos   (i_vpos),
    .o_inside (in_box)
  );

  assign bar_num      = i_hpos / BAR_WIDTH;
  assign bar_rgb      = (bar_num < 10'(NUM_BARS)) ? bar_colour(bar_num[2:0]) : 3'b000;
  assign on_border    = (i_hpos < BORDER_NEAR) || (i_hpos >= BORDER_RIGHT) ||
                        (i_vpos < BORDER_NEAR) || (i_vpos >= BORDER_BOTTOM);
  assign scroll_sum   = 11'(i_vpos) + 11'(frame_cnt_q);
  assign scroll_level = COLOR_BITS'(scroll_sum >> 2);
  assign hramp_level  = COLOR_BITS'(i_hpos >> (10 - COLOR_BITS));

  // Pixel colour for the displayed pattern; blanked outside the active area
  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (i_visible) begin
      case (active_q)
        PAT_BLACK: begin
          red_d = '0;
        end
        PAT_RED:   red_d = FULL;
        PAT_GREEN: grn_d = FULL;
        PAT_BLUE:  blu_d = FULL;
        PAT_BARS: begin
          red_d = {COLOR_BITS{bar_rgb[2]}};
          grn_d = {COLOR_BITS{bar_rgb[1]}};
          blu_d = {COLOR_BITS{bar_rgb[0]}};
        end
        PAT_BORDER: begin
          if (on_border) begin
            red_d = FULL;
            grn_d = FULL;
            blu_d = FULL;
          end
        end
        PAT_CHECKER: begin
          if (i_hpos[4] ^ i_vpos[4]) begin
            red_d = FULL;
            grn_d = FULL;
            blu_d = FULL;
          end
        end
        PAT_SCROLL: begin
          red_d = scroll_level;
          grn_d = scroll_level;
          blu_d = scroll_level;
        end
        PAT_BOX: begin
          blu_d = FULL;
          if (in_box) begin
            red_d = FULL;
            grn_d = FULL;
          end
        end
        PAT_HRAMP: begin
          red_d = hramp_level;
          grn_d = hramp_level;
          blu_d = hramp_level;
        end
        default: begin
          red_d = '0;
        end
      endcase
    end
  end

  // Output stage: colour and syncs registered together so they stay aligned
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_red_video <= '0;
      o_grn_video <= '0;
      o_blu_video <= '0;
      o_hsync     <= 1'b1;
      o_vsync     <= 1'b1;
    end else begin
      o_red_video <= red_d;
      o_grn_video <= grn_d;
      o_blu_video <= blu_d;
      o_hsync     <= i_hsync;
      o_vsync     <= i_vsync;
    end
  end

endmodule

// File: tb/tb_animated_pattern_gen.sv
// Self-checking bench for animated_pattern_gen (default parameters).
// Each cycle the expected output is predicted by a behavioural model and queued;
// the observed output is queued after the edge and test tasks compare the two.
module tb_animated_pattern_gen;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_pattern = 4'd0;
  logic       i_pattern_valid = 1'b0;
  logic       o_pattern_ready;
  logic [3:0] o_active_pattern;
  logic [9:0] i_hpos = 10'd0;
  logic [9:0] i_vpos = 10'd0;
  logic       i_visible = 1'b0;
  logic       i_hsync = 1'b1;
  logic       i_vsync = 1'b1;
  logic       i_frame_strobe = 1'b0;
  logic [2:0] o_red_video, o_grn_video, o_blu_video;
  logic       o_hsync, o_vsync;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic       hs;
    logic       vs;
    logic [3:0] act;
    logic       rdy;
  } vid_t;

  vid_t exp_q[$];
  vid_t obs_q[$];
  int   errors = 0;
  int   checks = 0;

  bit         m_pend;
  logic [3:0] m_pending;
  logic [3:0] m_active;
  int         m_fc, m_x, m_y;
  bit         m_dx, m_dy;

  animated_pattern_gen dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_pattern        (i_pattern),
    .i_pattern_valid  (i_pattern_valid),
    .o_pattern_ready  (o_pattern_ready),
    .o_active_pattern (o_active_pattern),
    .i_hpos           (i_hpos),
    .i_vpos           (i_vpos),
    .i_visible        (i_visible),
    .i_hsync          (i_hsync),
    .i_vsync          (i_vsync),
    .i_frame_strobe   (i_frame_strobe),
`ifdef TPG_FREEZE_EN
    .i_freeze         (1'b0),
`endif
    .o_red_video      (o_red_video),
    .o_grn_video      (o_grn_video),
    .o_blu_video      (o_blu_video),
    .o_hsync          (o_hsync),
    .o_vsync          (o_vsync)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [2:0] lvl(bit on);
    return on ? 3'd7 : 3'd0;
  endfunction

  // Expected {r,g,b} for a pixel using the model's current state
  function automatic logic [8:0] model_rgb(int h, int v, bit vis);
    logic [2:0] r, g, b, bits;
    int k;
    r = 0; g = 0; b = 0;
    if (vis) begin
      case (m_active)
        4'd1: r = 7;
        4'd2: g = 7;
        4'd3: b = 7;
        4'd4: begin
          k = h / 80;
          case (k)
            0: bits = 3'b111; 1: bits = 3'b110; 2: bits = 3'b011; 3: bits = 3'b010;
            4: bits = 3'b101; 5: bits = 3'b100; 6: bits = 3'b001; default: bits = 3'b000;
          endcase
          r = lvl(bits[2]); g = lvl(bits[1]); b = lvl(bits[0]);
        end
        4'd5: if (h < 8 || h >= 632 || v < 8 || v >= 472) begin r = 7; g = 7; b = 7; end
        4'd6: if ((((h >> 4) ^ (v >> 4)) & 1) == 1) begin r = 7; g = 7; b = 7; end
        4'd7: begin k = ((v + m_fc) >> 2) & 7; r = 3'(k); g = 3'(k); b = 3'(k); end
        4'd8: begin
          b = 7;
          if (h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32) begin r = 7; g = 7; end
        end
        4'd9: begin k = (h >> 7) & 7; r = 3'(k); g = 3'(k); b = 3'(k); end
        default: r = 0;
      endcase
    end
    return {r, g, b};
  endfunction

  // Drive one cycle, predict and queue the result, then capture the DUT output
  task automatic step(input bit rn, input int h, input int v, input bit vis,
                      input bit stb, input bit pv, input logic [3:0] pat);
    vid_t e;
    logic [8:0] rgb;
    bit hs, vs;
    int nx, ny;
    hs = 1'($urandom);
    vs = 1'($urandom);
    i_rst_n = rn; i_hpos = 10'(h); i_vpos = 10'(v); i_visible = vis;
    i_hsync = hs; i_vsync = vs; i_frame_strobe = stb;
    i_pattern_valid = pv; i_pattern = pat;
    if (!rn) begin
      e = {9'd0, 1'b1, 1'b1, 4'd0, 1'b1};
      m_pend = 0; m_pending = 0; m_active = 0; m_fc = 0;
      m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
    end else begin
      rgb = model_rgb(h, v, vis);
      if (!m_pend) begin
        if (pv) begin m_pend = 1; m_pending = pat; end
      end else if (stb) begin
        m_active = m_pending; m_pend = 0;
      end
      if (stb) begin
        m_fc = (m_fc + 1) % 256;
        nx = m_x + (m_dx ? 1 : -1);
        if (nx < 0 || nx > 608) begin m_dx = !m_dx; nx = m_x + (m_dx ? 1 : -1); end
        m_x = nx;
        ny = m_y + (m_dy ? 1 : -1);
        if (ny < 0 || ny > 448) begin m_dy = !m_dy; ny = m_y + (m_dy ? 1 : -1); end
        m_y = ny;
      end
      e = {rgb, hs, vs, m_active, !m_pend};
    end
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    obs_q.push_back({o_red_video, o_grn_video, o_blu_video, o_hsync, o_vsync,
                     o_active_pattern, o_pattern_ready});
  endtask

  task automatic pixel(input int h, input int v);
    step(1, h, v, 1, 0, 0, 4'd0);
  endtask

  task automatic strobe();
    step(1, $urandom_range(0, 639), $urandom_range(480, 520), 0, 1, 0, 4'd0);
  endtask

  task automatic request(input logic [3:0] pat);
    step(1, $urandom_range(0, 639), $urandom_range(0, 479), 1, 0, 1, pat);
  endtask

  task automatic test_reset();
    vid_t e, o;
    step(0, 10, 10, 1, 0, 0, 4'd0);
    step(0, 20, 20, 1, 1, 1, 4'd5);
    checks++;
    if ({o_red_video, o_grn_video, o_blu_video} !== 9'd0 || o_hsync !== 1'b1 ||
        o_vsync !== 1'b1 || o_pattern_ready !== 1'b1 || o_active_pattern !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got rgb=%h hs=%b vs=%b rdy=%b act=%0d want rgb=0 hs=1 vs=1 rdy=1 act=0",
               {o_red_video, o_grn_video, o_blu_video}, o_hsync, o_vsync, o_pattern_ready, o_active_pattern);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL reset_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_idle_frames();
    vid_t e, o;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 15; i++)
        step(1, $urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 0, 0, 4'd0);
      strobe();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL idle_frames: got %h want %h", o, e); end
    end
  endtask

  task automatic test_bars();
    vid_t e, o;
    pixel(30, 40);
    request(4'd4);
    checks++;
    if (o_pattern_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL bars_ready_drop: got %b want 0", o_pattern_ready);
    end
    for (int i = 0; i < 5; i++) pixel($urandom_range(0, 639), $urandom_range(0, 479));
    checks++;
    if (o_active_pattern !== 4'd0) begin
      errors++; $display("[TB] FAIL bars_early_switch: got %0d want 0", o_active_pattern);
    end
    strobe();
    checks++;
    if (o_active_pattern !== 4'd4 || o_pattern_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL bars_commit: got act=%0d rdy=%b want act=4 rdy=1",
                         o_active_pattern, o_pattern_ready);
    end
    pixel(100, 50);
    checks++;
    if (o_red_video !== 3'd7 || o_grn_video !== 3'd7 || o_blu_video !== 3'd0) begin
      errors++; $display("[TB] FAIL bars_yellow: got R=%0d G=%0d B=%0d want R=7 G=7 B=0",
                         o_red_video, o_grn_video, o_blu_video);
    end
    for (int i = 0; i < 8; i++) begin
      pixel(80 * i, 200);
      pixel(80 * i + 79, 201);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL bars_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_strobe_request();
    vid_t e, o;
    step(1, 5, 490, 0, 1, 1, 4'd7);
    checks++;
    if (o_active_pattern !== 4'd4 || o_pattern_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL strobe_req_first: got act=%0d rdy=%b want act=4 rdy=0",
                         o_active_pattern, o_pattern_ready);
    end
    for (int i = 0; i < 5; i++)
      step(1, $urandom_range(0, 639), $urandom_range(0, 479), 1, 0, 1, 4'd2);
    strobe();
    checks++;
    if (o_active_pattern !== 4'd7 || o_pattern_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL strobe_req_second: got act=%0d rdy=%b want act=7 rdy=1",
                         o_active_pattern, o_pattern_ready);
    end
    for (int i = 0; i < 6; i++) pixel($urandom_range(0, 639), $urandom_range(0, 479));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL strobe_req_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_scroll();
    vid_t e, o;
    int fc_start;
    fc_start = m_fc;
    for (int f = 0; f < 256; f++) begin
      pixel($urandom_range(0, 639), 0);
      pixel($urandom_range(0, 639), $urandom_range(0, 479));
      strobe();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL scroll_sb: frame %0d got %h want %h", f, o, e); end
      end
    end
    checks++;
    if (dut.frame_cnt_q !== 8'(fc_start)) begin
      errors++; $display("[TB] FAIL scroll_wrap: got %0d want %0d", dut.frame_cnt_q, fc_start);
    end
  endtask

  task automatic test_static_patterns();
    vid_t e, o;
    logic [3:0] pats [8];
    pats = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd9, 4'd12, 4'd0};
    foreach (pats[p]) begin
      request(pats[p]);
      strobe();
      for (int i = 0; i < 12; i++)
        step(1, $urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 3) != 0), 0, 0, 4'd0);
      pixel(7, 100); pixel(8, 100); pixel(631, 100); pixel(632, 100);
      pixel(100, 7); pixel(100, 8); pixel(100, 471); pixel(100, 472);
      pixel(15, 16); pixel(16, 16);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL static_pat%0d: got %h want %h", pats[p], o, e); end
      end
    end
  endtask

  task automatic test_box();
    vid_t e, o;
    int max_x, max_y;
    max_x = 0; max_y = 0;
    step(0, 0, 0, 0, 0, 0, 4'd0);
    request(4'd8);
    strobe();
    for (int f = 0; f < 615; f++) begin
      pixel(m_x, m_y);
      pixel(m_x + 31, m_y + 31);
      pixel(m_x + 32, m_y + 5);
      pixel(m_x + 5, m_y + 32);
      strobe();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL box_sb: frame %0d got %h want %h", f, o, e); end
      end
      checks++;
      if (int'(dut.u_box.x_q) != m_x || int'(dut.u_box.y_q) != m_y) begin
        errors++; $display("[TB] FAIL box_pos: frame %0d got (%0d,%0d) want (%0d,%0d)",
                           f, dut.u_box.x_q, dut.u_box.y_q, m_x, m_y);
      end
      if (int'(dut.u_box.x_q) > max_x) max_x = int'(dut.u_box.x_q);
      if (int'(dut.u_box.y_q) > max_y) max_y = int'(dut.u_box.y_q);
    end
    checks++;
    if (max_x != 608 || max_y != 448) begin
      errors++; $display("[TB] FAIL box_limits: got max (%0d,%0d) want (608,448)", max_x, max_y);
    end
  endtask

  task automatic test_visible_reset();
    vid_t e, o;
    request(4'd1);
    strobe();
    step(1, 100, 100, 0, 0, 0, 4'd0);
    pixel(100, 100);
    strobe();
    strobe();
    pixel(300, 200);
    step(0, 320, 240, 1, 0, 1, 4'd3);
    checks++;
    if ({o_red_video, o_grn_video, o_blu_video} !== 9'd0 || o_pattern_ready !== 1'b1 ||
        o_active_pattern !== 4'd0 || dut.u_box.x_q !== 10'd0 || dut.u_box.y_q !== 10'd0) begin
      errors++;
      $display("[TB] FAIL midframe_reset: got rgb=%h rdy=%b act=%0d box=(%0d,%0d) want rgb=0 rdy=1 act=0 box=(0,0)",
               {o_red_video, o_grn_video, o_blu_video}, o_pattern_ready, o_active_pattern,
               dut.u_box.x_q, dut.u_box.y_q);
    end
    pixel(321, 240);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL visible_reset_sb: got %h want %h", o, e); end
    end
  endtask

  initial begin
    $display("[TB] starting animated_pattern_gen bench");
    test_reset();
    test_idle_frames();
    test_bars();
    test_strobe_request();
    test_scroll();
    test_static_patterns();
    test_box();
    test_visible_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/animated_pattern_gen.md
Name: animated_pattern_gen

Overview:
- Parametrised successor to the VGA test pattern generator. Adds configurable colour depth, a frame-synchronous pattern-change handshake, a frame counter with animated patterns (scrolling gradient, bouncing box) and sync pass-through aligned to the registered video.
- Sits between the VGA sync generator (hpos/vpos/visible/syncs/frame strobe) and the video DAC pins.

Parameters:
- COLOR_BITS, 3, bits per colour channel; legal range 1..8.
- H_VISIBLE, 640, visible pixels per line.
- V_VISIBLE, 480, visible lines per frame.
- BORDER_WIDTH, 8, border thickness in pixels for pattern 5.
- BOX_SIZE, 32, bouncing box edge length in pixels; must be less than both V_VISIBLE and H_VISIBLE.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  synchronous reset, active-low
- i_pattern  in  4  requested pattern ID
- i_pattern_valid  in  1  request qualifier
- o_pattern_ready  out  1  high when a request can be accepted
- o_active_pattern  out  4  pattern currently being displayed
- i_hpos  in  10  pixel column
- i_vpos  in  10  pixel row
- i_visible  in  1  in the active area
- i_hsync  in  1  raw horizontal sync
- i_vsync  in  1  raw vertical sync
- i_frame_strobe  in  1  one-cycle pulse per frame
- o_red_video  out  COLOR_BITS  red channel
- o_grn_video  out  COLOR_BITS  green channel
- o_blu_video  out  COLOR_BITS  blue channel
- o_hsync  out  1  delayed hsync
- o_vsync  out  1  delayed vsync

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset values:
  - colour outputs 0; o_hsync/o_vsync 1.
  - o_active_pattern 0; pending register empty; o_pattern_ready 1.
  - frame counter 0.
  - box x=0, y=0, both directions positive.
  - Reset asserted mid-frame returns all state to these values on the next edge.
- Handshake:
  - A request is accepted when i_pattern_valid && o_pattern_ready; the ID is stored in a pending register and o_pattern_ready drops the following cycle.
  - On the first i_frame_strobe strictly after acceptance, o_active_pattern loads the pending ID, the pending register clears and o_pattern_ready returns high next cycle.
  - A request accepted in the same cycle as a strobe waits for the following strobe.
  - Valid held while ready is low is ignored, with no loss of the pending value.
- Frame counter: 8-bit, increments on each i_frame_strobe, wraps 255->0.
- Bouncing box: moves on each strobe by 1 pixel per axis.
  - x range 0..H_VISIBLE-BOX_SIZE; y range 0..V_VISIBLE-BOX_SIZE.
  - When the position is at a limit and moving outward, the direction bit flips and the position steps inward in the same update, so the box never leaves range.
- Patterns, with F = full scale (all COLOR_BITS ones):
  - 0: black.
  - 1: red F.
  - 2: green F.
  - 3: blue F.
  - 4: eight vertical colour bars, width H_VISIBLE/8, order white, yellow, cyan, green, magenta, red, blue, black.
  - 5: white border of BORDER_WIDTH on black.
  - 6: checkerboard of 16x16 cells, white where hpos[4]^vpos[4], else black.
  - 7: scrolling grey ramp. Sum s = vpos + frame counter (11-bit); all channels = s[COLOR_BITS+1:2], zero-extended if COLOR_BITS exceeds available bits.
  - 8: white box on blue F background; a pixel is inside when x<=hpos<x+BOX_SIZE and y<=vpos<y+BOX_SIZE.
  - 9: horizontal grey ramp, all channels = i_hpos[9:10-COLOR_BITS].
  - 10..15: black, still accepted and reported on o_active_pattern.
- Latency: exactly 1 cycle from inputs to colour and sync outputs. Syncs are registered in the same stage, so colour and sync stay aligned. When i_visible=0 the registered colour is 0 regardless of pattern.
- Animation state updates on strobe edges only; a pattern switch never tears mid-frame.

Optional Feature:
- TPG_FREEZE_EN.
  - When defined: adds input i_freeze (1 bit). While i_freeze=1, the frame counter and box position and direction hold. Pattern handshake is unaffected.
  - When undefined: the port is absent and animation always runs.

Decomposition:
- Shared include tpg_defs.vh holds:
  - pattern ID localparams (PAT_BLACK..PAT_HRAMP);
  - colour-bar ordering;
  - frame-counter width.
- Sub-module tpg_bounce_box holds the x/y position registers, direction bits and edge-reversal logic, with an inside-box flag output.

Test Plan:
- Reset then 3 frames, no request -> o_active_pattern=0, colour always 0, o_hsync/o_vsync equal to inputs delayed exactly 1 cycle.
- Request 4 mid-frame -> o_pattern_ready=0 next cycle; o_active_pattern=4 only after the next strobe; at hpos=100 (bar 1, yellow) the output is R=7, G=7, B=0.
- Request 7 asserted on a strobe cycle -> pattern applied at the second strobe, not the first.
- Pattern 8 run 610 frames -> x reaches 608 then returns to 607 on the next strobe; y bounces at 448; the box is never out of range.
- Pattern 7 across 256 strobes -> frame counter wraps to 0; at vpos=0 the output equals the counter's bits [4:2] each frame.
- i_visible=0 with pattern 1 -> output 0; reset asserted mid-frame -> next cycle outputs 0, ready=1, box at (0,0).
